// File: rtl/write_select_pipe.sv
`default_nettype none
// ============================================================================
// Module   : write_select_pipe
// Purpose  : Write-side register-select pipeline. Decodes the destination
//            register and write enable of each issued instruction, carries
//            them through a DEPTH-stage shift pipeline to write-back and drives
//            the register file write port. Also tracks every in-flight
//            destination and flags read-after-write hazards on the current
//            read selects.
// Ports    : clk           - clock, all state updates on the rising edge
//            reset         - synchronous, active-high, clears all state
//            instructions  - instruction at issue ([31:26] opcode, [25:21] dest)
//            instr_valid   - instructions holds a real instruction this cycle
//            stall         - issue held; a bubble enters stage 0
//            flush         - kill every in-flight instruction
//            readSelect1/2 - current read selects
//            writeSelect   - register file write address (registered)
//            writeEnable   - register file write strobe (registered)
//            pending_mask  - bit r set while any stage holds a write to r
//            hazard        - combinational RAW hazard on the read selects
// Revision : 1.0 - initial release
// ============================================================================
module write_select_pipe #(
    parameter int DEPTH = 3,
    parameter int RA_W  = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            instructions,
    input  logic                   instr_valid,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [RA_W-1:0]        readSelect1,
    input  logic [RA_W-1:0]        readSelect2,
    output logic [RA_W-1:0]        writeSelect,
    output logic                   writeEnable,
    output logic [(1<<RA_W)-1:0]   pending_mask,
    output logic                   hazard
);

    localparam int NREG = 1 << RA_W;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [5:0]      w_opcode;
    logic [RA_W-1:0] w_dest;
    logic            w_opWrites;
    logic            w_decWe;
    logic            w_issue;
    logic            w_unusedBits;

    assign w_opcode = instructions[31:26];
    assign w_dest   = RA_W'(instructions[25:21]);

    // Immediate/function fields and opcode[2:1] play no part in the write port.
    assign w_unusedBits = ^{w_opcode[2:1], instructions[20:0]};

    always_comb begin
        w_opWrites = 1'b0;
        casez (w_opcode[5:3])
            3'b01?:  w_opWrites = 1'b1;          // R-type
            3'b110:  w_opWrites = 1'b1;          // I-type ALU
            3'b111:  w_opWrites = ~w_opcode[0];  // load writes, store does not
            default: w_opWrites = 1'b0;          // branch, nop, reserved
        endcase
    end

    // Register 0 is hardwired, so a write to it is dropped at decode.
    assign w_decWe = w_opWrites && (w_dest != '0);
    assign w_issue = instr_valid && !stall;

    // ------------------------------------------------------------------
    // Shift pipeline
    // ------------------------------------------------------------------
    logic            r_stageWe   [DEPTH];
    logic [RA_W-1:0] r_stageAddr [DEPTH];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stageWe[i]   <= 1'b0;
                r_stageAddr[i] <= '0;
            end
        end else begin
            // Address is zeroed for non-writes so the write port stays quiet.
            r_stageWe[0]   <= w_issue && w_decWe;
            r_stageAddr[0] <= (w_issue && w_decWe) ? w_dest : '0;
            for (int i = 1; i < DEPTH; i++) begin
                r_stageWe[i]   <= r_stageWe[i-1];
                r_stageAddr[i] <= r_stageAddr[i-1];
            end
        end
    end

    assign writeSelect = r_stageAddr[DEPTH-1];
    assign writeEnable = r_stageWe[DEPTH-1];

    // ------------------------------------------------------------------
    // In-flight tracking and hazard detection
    // ------------------------------------------------------------------
    logic [NREG-1:0] w_pending;

    always_comb begin
        w_pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_stageWe[i]) begin
                w_pending[r_stageAddr[i]] = 1'b1;
            end
        end
        w_pending[0] = 1'b0;
    end

    assign pending_mask = w_pending;

    // The output stage is still pending: the register file has no write-through.
    assign hazard = instr_valid &&
                    (((readSelect1 != '0) && w_pending[readSelect1]) ||
                     ((readSelect2 != '0) && w_pending[readSelect2]));

endmodule
`default_nettype wire

// File: tb/tb_write_select_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_write_select_pipe
// Purpose  : Directed self-checking bench for write_select_pipe (DEPTH=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_write_select_pipe;

    logic        clk;
    logic        reset;
    logic [31:0] instructions;
    logic        instr_valid;
    logic        stall;
    logic        flush;
    logic [4:0]  readSelect1;
    logic [4:0]  readSelect2;
    logic [4:0]  writeSelect;
    logic        writeEnable;
    logic [31:0] pending_mask;
    logic        hazard;

    int nCompared   = 0;
    int nMismatched = 0;

    write_select_pipe #(.DEPTH(3), .RA_W(5)) dut (
        .clk          (clk),
        .reset        (reset),
        .instructions (instructions),
        .instr_valid  (instr_valid),
        .stall        (stall),
        .flush        (flush),
        .readSelect1  (readSelect1),
        .readSelect2  (readSelect2),
        .writeSelect  (writeSelect),
        .writeEnable  (writeEnable),
        .pending_mask (pending_mask),
        .hazard       (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] dst);
        return {op, dst, 21'd0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic we, input logic [4:0] sel,
                        input logic [31:0] mask);
        chk({tag, ".we"},   {31'd0, writeEnable}, {31'd0, we});
        if (we) chk({tag, ".sel"}, {27'd0, writeSelect}, {27'd0, sel});
        chk({tag, ".mask"}, pending_mask, mask);
    endtask

    initial begin
        reset = 1'b1; instructions = 32'd0; instr_valid = 1'b0;
        stall = 1'b0; flush = 1'b0; readSelect1 = 5'd0; readSelect2 = 5'd0;
        step(); step();
        chk("reset.we",   {31'd0, writeEnable}, 32'd0);
        chk("reset.sel",  {27'd0, writeSelect}, 32'd0);
        chk("reset.mask", pending_mask, 32'd0);
        reset = 1'b0;

        // 1: R-type dest 3, latency 3
        instructions = 32'b010010_00011_00000_00001_00000000000; instr_valid = 1'b1;
        step(); instr_valid = 1'b0; instructions = 32'd0;
        outs("t1c1", 1'b0, 5'd0, 32'h8);
        step(); outs("t1c2", 1'b0, 5'd0, 32'h8);
        step(); outs("t1c3", 1'b1, 5'd3, 32'h8);
        step(); outs("t1c4", 1'b0, 5'd0, 32'h0);

        // 2: branch and store never write; load does
        instructions = 32'b100000_00001_00010_00011_00000000000; instr_valid = 1'b1;
        step(); outs("t2br", 1'b0, 5'd0, 32'h0);
        instructions = mk(6'b111011, 5'd2);
        step(); outs("t2st", 1'b0, 5'd0, 32'h0);
        instructions = mk(6'b111010, 5'd1);
        step(); instr_valid = 1'b0; instructions = 32'd0;
        outs("t2ld1", 1'b0, 5'd0, 32'h2);
        step(); outs("t2ld2", 1'b0, 5'd0, 32'h2);
        step(); outs("t2ld3", 1'b1, 5'd1, 32'h2);
        step(); outs("t2ld4", 1'b0, 5'd0, 32'h0);

        // 3: hazards
        instructions = mk(6'b010000, 5'd3); instr_valid = 1'b1;
        step();
        instructions = 32'd0; readSelect1 = 5'd3; #1;
        chk("t3.hz_rs1", {31'd0, hazard}, 32'd1);
        readSelect1 = 5'd0; #1;
        chk("t3.hz_none", {31'd0, hazard}, 32'd0);
        readSelect2 = 5'd3; #1;
        chk("t3.hz_rs2", {31'd0, hazard}, 32'd1);
        instr_valid = 1'b0; #1;
        chk("t3.hz_novalid", {31'd0, hazard}, 32'd0);
        readSelect2 = 5'd0;
        step(); step();
        instr_valid = 1'b1; readSelect1 = 5'd3; #1;
        chk("t3.hz_outstage", {31'd0, hazard}, 32'd1);
        outs("t3out", 1'b1, 5'd3, 32'h8);
        instr_valid = 1'b0; readSelect1 = 5'd0;
        step(); outs("t3drain", 1'b0, 5'd0, 32'h0);
        instructions = mk(6'b010000, 5'd0); instr_valid = 1'b1;
        step(); instr_valid = 1'b0; instructions = 32'd0;
        outs("t3r0a", 1'b0, 5'd0, 32'h0);
        step(); step(); outs("t3r0c", 1'b0, 5'd0, 32'h0);
        step();

        // 4: stalled instruction is dropped, earlier write drains on time
        instructions = mk(6'b010000, 5'd7); instr_valid = 1'b1;
        step();
        instructions = mk(6'b010000, 5'd6); stall = 1'b1;
        step(); stall = 1'b0; instr_valid = 1'b0; instructions = 32'd0;
        outs("t4c2", 1'b0, 5'd0, 32'h80);
        step(); outs("t4c3", 1'b1, 5'd7, 32'h80);
        step(); outs("t4c4", 1'b0, 5'd0, 32'h0);
        step(); outs("t4c5", 1'b0, 5'd0, 32'h0);

        // 5: flush kills in-flight writes and the flush-cycle instruction
        instructions = mk(6'b010000, 5'd2); instr_valid = 1'b1;
        step();
        instructions = mk(6'b110000, 5'd4);
        step(); outs("t5pre", 1'b0, 5'd0, 32'h14);
        instructions = mk(6'b010000, 5'd5); flush = 1'b1;
        step(); flush = 1'b0; instr_valid = 1'b0; instructions = 32'd0;
        outs("t5f1", 1'b0, 5'd0, 32'h0);
        step(); step(); outs("t5f3", 1'b0, 5'd0, 32'h0);

        // 6: reset with full pipeline, then back-to-back writes to r5
        instr_valid = 1'b1;
        instructions = mk(6'b010000, 5'd1); step();
        instructions = mk(6'b010000, 5'd2); step();
        instructions = mk(6'b010000, 5'd3); step();
        instr_valid = 1'b0; instructions = 32'd0;
        outs("t6full", 1'b1, 5'd1, 32'hE);
        reset = 1'b1;
        step(); reset = 1'b0;
        chk("t6rst.we",   {31'd0, writeEnable}, 32'd0);
        chk("t6rst.sel",  {27'd0, writeSelect}, 32'd0);
        chk("t6rst.mask", pending_mask, 32'd0);
        instructions = mk(6'b010000, 5'd5); instr_valid = 1'b1;
        step(); step(); instr_valid = 1'b0; instructions = 32'd0;
        outs("t6b2", 1'b0, 5'd0, 32'h20);
        step(); outs("t6b3", 1'b1, 5'd5, 32'h20);
        step(); outs("t6b4", 1'b1, 5'd5, 32'h20);
        step(); outs("t6b5", 1'b0, 5'd0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
